// File: rtl/serial_binary_subtractor_if.sv
// Request/result bundle for serial_binary_subtractor.
// The master drives load/decrement requests and observes the registered count,
// busy, done and underflow outputs. The slave is the subtractor itself.
interface serial_binary_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             decrement;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             underflow;

    modport master (
        output load, load_value, decrement,
        input  count, busy, done, underflow
    );

    modport slave (
        input  load, load_value, decrement,
        output count, busy, done, underflow
    );
endinterface

// File: rtl/serial_binary_subtractor.sv
// Bit-serial down-counter: holds a WIDTH-bit count and, on each accepted
// decrement request, subtracts 1 LSB-first, one bit per clock, rippling a
// borrow. A one-cycle done pulse marks the final result, and underflow flags
// a wrap from 0 to all-ones.
//
// Optional feature, enabled by defining SERIAL_SUB_EARLY_EXIT_EN:
//   finish as soon as the borrow dies out, because the remaining upper bits
//   cannot change. A count of 0 still takes all WIDTH cycles.
module serial_binary_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,   // asynchronous, active low
    serial_binary_subtractor_if.slave   bus
);

    localparam int              IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SUB,
        ST_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               borrow_q, borrow_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               underflow_q, underflow_d;

    logic               bit_borrow;   // borrow produced by the bit at idx_q
    logic               last_bit;     // idx_q addresses the MSB
    logic               sub_exit;     // this SUB cycle is the final one

    // Next-state, datapath and registered-output logic.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned; otherwise synthesis infers a latch.
        state_d     = state_q;
        count_d     = count_q;
        idx_d       = idx_q;
        borrow_d    = borrow_q;

        bit_borrow  = borrow_q & ~count_q[idx_q];
        last_bit    = (idx_q == LAST_IDX);
`ifdef SERIAL_SUB_EARLY_EXIT_EN
        // Once the borrow is gone the upper bits are already final.
        sub_exit    = last_bit | ~bit_borrow;
`else
        sub_exit    = last_bit;
`endif

        unique case (state_q)
            ST_IDLE: begin
                // Load wins over decrement; a simultaneous decrement is dropped.
                if (bus.load) begin
                    count_d = bus.load_value;
                end else if (bus.decrement) begin
                    idx_d    = '0;
                    borrow_d = 1'b1;
                    state_d  = ST_SUB;
                end
            end
            ST_SUB: begin
                // The new borrow uses the old bit value, before it is flipped.
                count_d[idx_q] = count_q[idx_q] ^ borrow_q;
                borrow_d       = bit_borrow;
                idx_d          = idx_q + 1'b1;
                if (sub_exit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the next state.
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
        underflow_d = (state_q == ST_SUB) && sub_exit && bit_borrow;
    end

    // State and output registers; reset takes effect immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            idx_q       <= '0;
            borrow_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every flop samples the values
            // from before this edge regardless of statement order.
            state_q     <= state_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            borrow_q    <= borrow_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.count     = count_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.underflow = underflow_q;

endmodule

// File: doc/serial_binary_subtractor.md
Name: serial_binary_subtractor

Overview:
Bit-serial down-counter FSM, the decrement counterpart of the team's serial binary adder/incrementer.
- Holds a WIDTH-bit count register.
- On each accepted decrement request, subtracts 1 LSB-first, one bit per clock, propagating a borrow.
- Signals completion with a one-cycle done pulse and flags wrap-around from 0.
- Sits beside the incrementer in the sequential-circuit library; intended for countdown/timer datapaths.

Parameters:
WIDTH, 4, bit width of count register and load_value (legal: 2..16)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
load  input  1  parallel-load request, honoured only in IDLE
load_value  input  WIDTH  value written to count on an accepted load
decrement  input  1  decrement request, honoured only in IDLE
count  output  WIDTH  current count register (registered)
busy  output  1  high while in SUB or DONE
done  output  1  one-cycle pulse; count holds final result in this cycle
underflow  output  1  one-cycle pulse coincident with done when 0 wrapped to 2^WIDTH-1

Behaviour:
- Reset (reset=0, async): state=IDLE, count=0, bit index=0, borrow=0, busy=0, done=0, underflow=0. Effect is immediate and overrides any operation in progress; release is synchronous to clk.
- States: IDLE, SUB, DONE. State and all outputs are registered.
- IDLE:
  - load=1 -> count<=load_value, stay IDLE.
  - Else decrement=1 -> idx<=0, borrow<=1, go SUB.
  - Load has priority: load and decrement together -> load only; the decrement is dropped, not queued.
- SUB, each cycle:
  - count[idx]<=count[idx]^borrow
  - borrow<=borrow&~count[idx] (uses old bit)
  - idx<=idx+1
  - After processing idx=WIDTH-1 -> DONE.
  - Partially updated count is visible during SUB; consumers sample only on done.
- DONE (one cycle): done=1; underflow=1 if final borrow=1. Next cycle: IDLE, done=0, underflow=0.
- Latency (base build): decrement sampled at edge N -> SUB during cycles N+1..N+WIDTH -> done=1 in cycle N+WIDTH+1 -> ready for a new request at edge N+WIDTH+2.
- load and decrement asserted while busy=1 are ignored entirely.
- Arithmetic: modulo 2^WIDTH. 0-1 = 2^WIDTH-1 with underflow=1; all other inputs give underflow=0.
- Holding decrement high back-to-back gives one decrement per WIDTH+2 cycles.

Optional Feature:
Macro: SERIAL_SUB_EARLY_EXIT_EN
- Defined: when the borrow computed for the current bit is 0, remaining bits are unchanged, so the FSM goes directly from SUB to DONE after that bit. Latency becomes (index of lowest 1 bit)+1 SUB cycles. When count=0 the FSM still runs all WIDTH cycles. Result, done and underflow semantics are unchanged.
- Undefined: always exactly WIDTH SUB cycles. No early-exit logic is synthesised.

Test Plan:
1. WIDTH=4: reset, load 4'b0111, pulse decrement -> busy high 5 cycles, done pulse with count=4'b0110, underflow=0. With EARLY_EXIT_EN: done after 1 SUB cycle.
2. Load 4'b0000, decrement -> count=4'b1111, done=1 and underflow=1 in the same cycle; next cycle both 0.
3. Load 4'b1000, decrement -> count=4'b0111 (full borrow chain). EARLY_EXIT_EN: 4 SUB cycles.
4. In IDLE, load=1 with load_value=4'b0101 and decrement=1 together -> count=4'b0101, busy stays 0. Then decrement -> 4'b0100.
5. During SUB, assert load (4'b1111) and a second decrement -> both ignored, single result 6 from an initial 7.
6. Load 4'b0111, decrement, drop reset to 0 at the 2nd SUB cycle -> count=0, busy=done=underflow=0 immediately. After release, decrement -> count=4'b1111, underflow=1.
